// File: rtl/ds1302write_if.sv
// Host-side signal bundle for the DS1302 single-byte writer.
// The bidirectional data line stays a plain port on the writer itself.
interface ds1302write_if;
    logic       en;
    logic [7:0] cmd;
    logic [7:0] wrData;
    logic       sclk;
    logic       ce;
    logic       busy;
    logic       done;

    modport master (output en, cmd, wrData, sclk, input ce, busy, done);
    modport slave  (input en, cmd, wrData, sclk, output ce, busy, done);
endinterface

// File: rtl/ds1302write.sv
// Writes one command byte plus one data byte, LSB first, to a DS1302 over its
// 3-wire interface, pacing every bit from the shared free-running SCLK.
module ds1302write (
    input  logic          clk,
    input  logic          rst,
    ds1302write_if.slave  bus,
    inout  wire           dsData
);
    typedef enum logic [2:0] {IDLE, ALIGN, SHIFT, LAST, GAP} state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    logic        ce_q;
    logic        io_dir_q;
    logic        done_q;
    logic        sclk_dly_q;

    logic        sclk_rise;
    logic        sclk_fall;
    logic [7:0]  cmd_forced;
    logic [15:0] load_d;
    logic [15:0] shift_d;
    logic [4:0]  cnt_d;

    assign sclk_rise  = bus.sclk & ~sclk_dly_q;
    assign sclk_fall  = ~bus.sclk & sclk_dly_q;
    // Every command issued here is a write: bit7 set, R/W bit cleared.
    assign cmd_forced = (bus.cmd | 8'h80) & 8'hFE;
    assign load_d     = {bus.wrData, cmd_forced};
    assign shift_d    = {1'b0, shift_q[15:1]};
    assign cnt_d      = cnt_q + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ce_q       <= 1'b0;
            io_dir_q   <= 1'b0;
            done_q     <= 1'b0;
            sclk_dly_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees the pre-edge register values.
            sclk_dly_q <= bus.sclk;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        shift_q  <= load_d;
                        ce_q     <= 1'b1;
                        io_dir_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (sclk_fall) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == 5'd16) state_q <= LAST;
                    end
                    if (sclk_fall) shift_q <= shift_d;
                end
                LAST: begin
                    // Hold CE and data through the high half of the final bit.
                    if (sclk_fall) begin
                        ce_q     <= 1'b0;
                        io_dir_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    if (sclk_fall) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dsData   = io_dir_q ? shift_q[0] : 1'bz;
    assign bus.ce   = ce_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_ds1302write.sv
// Directed bench for ds1302write: a behavioural DS1302 slave captures the bits
// sampled on SCLK rise while CE is high; the data line has a pull-up so a released line reads 1.
module tb_ds1302write;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    wire  ds_data;
    pullup (ds_data);

    ds1302write_if bus ();
    assign bus.sclk = sclk;

    ds1302write dut (.clk(clk), .rst(rst), .bus(bus.slave), .dsData(ds_data));

    always #5 clk = ~clk;

    // SCLK period = 8 clk, toggled away from the active clk edge.
    int div = 0;
    always @(negedge clk) begin
        if (div == 3) begin
            div  = 0;
            sclk = ~sclk;
        end else begin
            div++;
        end
    end

    logic [15:0] cap = '0;
    int nrise = 0;
    always @(posedge sclk) begin
        if (bus.ce === 1'b1) begin
            cap = {ds_data, cap[15:1]};
            nrise++;
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    int checks = 0;
    int errors = 0;

    task automatic start(input logic [7:0] c, input logic [7:0] d);
        @(posedge sclk);
        bus.cmd = c; bus.wrData = d; bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rises(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (nrise >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.cmd = '0; bus.wrData = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ce !== 1'b0)   begin errors++; $display("FAIL reset_ce got %b exp 0", bus.ce); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (ds_data !== 1'b1)  begin errors++; $display("FAIL reset_release got %b exp 1", ds_data); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int base = done_cnt;
        bit ok, ok2;
        nrise = 0;
        start(8'h80, 8'h45);
        wait_done(base + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 exp 1"); end
        wait_idle(ok2);
        checks++; if (!ok2) begin errors++; $display("FAIL basic_idle_timeout got 0 exp 1"); end
        checks++; if (cap !== 16'h4580)  begin errors++; $display("FAIL basic_bits got %h exp 4580", cap); end
        checks++; if (nrise != 16)       begin errors++; $display("FAIL basic_rises got %0d exp 16", nrise); end
        checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL basic_done_count got %0d exp %0d", done_cnt - base, 1); end
        checks++; if (bus.ce !== 1'b0)   begin errors++; $display("FAIL basic_ce_after got %b exp 0", bus.ce); end
        checks++; if (ds_data !== 1'b1)  begin errors++; $display("FAIL basic_release got %b exp 1", ds_data); end
    endtask

    task automatic test_wp_clear();
        int base = done_cnt;
        bit ok, ok2;
        nrise = 0;
        start(8'h8E, 8'h00);
        wait_done(base + 1, ok);
        wait_idle(ok2);
        checks++; if (!(ok && ok2))     begin errors++; $display("FAIL wp_timeout got %b%b exp 11", ok, ok2); end
        checks++; if (cap !== 16'h008E) begin errors++; $display("FAIL wp_bits got %h exp 008e", cap); end
        checks++; if (nrise != 16)      begin errors++; $display("FAIL wp_rises got %0d exp 16", nrise); end
    endtask

    task automatic test_forced_write();
        int base = done_cnt;
        bit ok, ok2;
        nrise = 0;
        start(8'h81, 8'hA5);
        wait_done(base + 1, ok);
        wait_idle(ok2);
        checks++; if (!(ok && ok2))     begin errors++; $display("FAIL forced_timeout got %b%b exp 11", ok, ok2); end
        checks++; if (cap !== 16'hA580) begin errors++; $display("FAIL forced_rw_bits got %h exp a580", cap); end
        nrise = 0;
        start(8'h0C, 8'h5A);
        wait_done(base + 2, ok);
        wait_idle(ok2);
        checks++; if (!(ok && ok2))     begin errors++; $display("FAIL forced7_timeout got %b%b exp 11", ok, ok2); end
        checks++; if (cap !== 16'h5A8C) begin errors++; $display("FAIL forced_bit7_bits got %h exp 5a8c", cap); end
    endtask

    task automatic test_en_while_busy();
        int base = done_cnt;
        bit ok, ok2;
        nrise = 0;
        start(8'h8C, 8'h33);
        wait_rises(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_rise_timeout got 0 exp 1"); end
        bus.cmd = 8'h82; bus.wrData = 8'h77; bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_done(base + 1, ok);
        wait_idle(ok2);
        repeat (40) @(negedge clk);
        checks++; if (!(ok && ok2))         begin errors++; $display("FAIL busy_timeout got %b%b exp 11", ok, ok2); end
        checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", done_cnt - base); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL busy_requeued got %b exp 0", bus.busy); end
        checks++; if (cap !== 16'h338C)     begin errors++; $display("FAIL busy_bits got %h exp 338c", cap); end
        checks++; if (nrise != 16)          begin errors++; $display("FAIL busy_rises got %0d exp 16", nrise); end
    endtask

    task automatic test_reset_mid();
        int base = done_cnt;
        bit ok, ok2;
        nrise = 0;
        start(8'hC0, 8'hFF);
        wait_rises(5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_rise_timeout got 0 exp 1"); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.ce !== 1'b0)   begin errors++; $display("FAIL rstmid_ce got %b exp 0", bus.ce); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
        checks++; if (ds_data !== 1'b1)  begin errors++; $display("FAIL rstmid_release got %b exp 1", ds_data); end
        repeat (20) @(negedge clk);
        checks++; if (done_cnt != base)  begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt - base); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nrise = 0;
        start(8'h84, 8'h12);
        wait_done(base + 1, ok);
        wait_idle(ok2);
        checks++; if (!(ok && ok2))     begin errors++; $display("FAIL rstmid_after_timeout got %b%b exp 11", ok, ok2); end
        checks++; if (cap !== 16'h1284) begin errors++; $display("FAIL rstmid_after_bits got %h exp 1284", cap); end
        checks++; if (nrise != 16)      begin errors++; $display("FAIL rstmid_after_rises got %0d exp 16", nrise); end
    endtask

    task automatic test_back_to_back();
        int base = done_cnt;
        int gap = 0;
        bit ok, ok2;
        nrise = 0;
        @(posedge sclk);
        bus.cmd = 8'h82; bus.wrData = 8'h01; bus.en = 1'b1;
        wait_done(base + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout got 0 exp 1"); end
        while (bus.ce === 1'b0 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        checks++; if (bus.ce !== 1'b1 || gap < 8) begin errors++; $display("FAIL b2b_gap got %0d clk ce=%b exp >=8 clk ce=1", gap, bus.ce); end
        wait_done(base + 2, ok);
        bus.en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got 0 exp 1"); end
        wait_idle(ok2);
        repeat (30) @(negedge clk);
        checks++; if (!ok2)                 begin errors++; $display("FAIL b2b_idle_timeout got 0 exp 1"); end
        checks++; if (done_cnt != base + 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt - base); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL b2b_busy_after got %b exp 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wp_clear();
        test_forced_write();
        test_en_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
